// File: rtl/face_auth_pkg.sv
// Shared state encoding, default geometry and threshold helper for the face-auth sequencer.
package face_auth_pkg;

  localparam int N_BITS_DEF     = 2816;
  localparam int ADDR_W_DEF     = 12;
  localparam int THRESH_PCT_DEF = 90;

  typedef enum logic [2:0] {
    FA_IDLE,
    FA_SCAN,
    FA_DRAIN,
    FA_DECIDE,
    FA_GRANTED
  } fa_state_t;

  // Right-hand side of count*100 >= pct*n_bits, evaluated as a 32-bit unsigned constant.
  function automatic logic [31:0] fa_thresh_product(input int unsigned pct, input int unsigned n_bits);
    return 32'(pct * n_bits);
  endfunction

endpackage

// File: rtl/face_auth_sequencer_if.sv
// Signal bundle between the sequencer, the two LBP memories and the vend FSM.
interface face_auth_sequencer_if #(
  parameter int ADDR_W = face_auth_pkg::ADDR_W_DEF
);
  logic              start;
  logic              revoke;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              user_bit;
  logic              ref_bit;
  logic              busy;
  logic              done;
  logic              granted;
  logic [ADDR_W-1:0] match_count;

  modport slave (
    input  start, revoke, user_bit, ref_bit,
    output rd_en, rd_addr, busy, done, granted, match_count
  );

  modport master (
    output start, revoke, user_bit, ref_bit,
    input  rd_en, rd_addr, busy, done, granted, match_count
  );
endinterface

// File: rtl/lbp_match_counter.sv
// Counts bit-equal positions of two memory read streams, qualified by the read strobe delayed one cycle.
module lbp_match_counter
  import face_auth_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              valid,
  input  logic              a,
  input  logic              b,
  output logic [ADDR_W-1:0] count
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_valid <= valid & ~clear;
      if (clear) begin
        r_count <= '0;
      end else if (r_valid && (a == b)) begin
        r_count <= r_count + ADDR_W'(1);
      end
    end
  end

  assign count = r_count;

endmodule

// File: rtl/face_auth_sequencer.sv
// Face-recognition gate: scans user vs reference LBP bits and grants vending on a match threshold.
// Grant lifetime limit is built only when FACE_AUTH_TIMEOUT_EN is defined.
//   state   | meaning
//   IDLE    | waiting for start
//   SCAN    | issuing reads, rd_addr 0..N_BITS-1
//   DRAIN   | last read returning, no new read
//   DECIDE  | done pulse, granted shows the verdict
//   GRANTED | grant held until revoke, start or timeout
module face_auth_sequencer
  import face_auth_pkg::*;
#(
  parameter int          N_BITS         = N_BITS_DEF,
  parameter int          ADDR_W         = ADDR_W_DEF,
  parameter int          THRESH_PCT     = THRESH_PCT_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic                  clk,
  input logic                  reset,
  face_auth_sequencer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(N_BITS - 1);
  localparam logic [31:0]       THRESH_PROD = fa_thresh_product(THRESH_PCT, N_BITS);

  if ((64'd1 << ADDR_W) <= 64'(N_BITS)) begin : g_chk_addr_w
    $error("ADDR_W too narrow to address N_BITS");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_chk_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  fa_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_rd_addr, w_addr_nxt;
  logic              r_rd_en, r_busy, r_done, r_granted;
  logic              w_granted_nxt, w_clear, w_timeout, w_hit, w_pass;
  logic [ADDR_W-1:0] w_count, w_final_count;

  lbp_match_counter #(.ADDR_W(ADDR_W)) u_match (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .valid (r_rd_en),
    .a     (bus.user_bit),
    .b     (bus.ref_bit),
    .count (w_count)
  );

  // In DRAIN the last returned bit is still in flight, so the verdict folds it in
  // directly; this lets granted rise in the same cycle as done.
  assign w_hit         = (bus.user_bit == bus.ref_bit);
  assign w_final_count = w_count + ADDR_W'(w_hit);
  assign w_pass        = ((32'(w_final_count) * 32'd100) >= THRESH_PROD);

`ifdef FACE_AUTH_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state != FA_GRANTED) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end
  end

  assign w_timeout = (r_state == FA_GRANTED) && (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_rd_addr;
    w_granted_nxt = r_granted;
    w_clear       = 1'b0;
    case (r_state)
      FA_IDLE: begin
        if (bus.start) begin
          w_state_nxt   = FA_SCAN;
          w_addr_nxt    = '0;
          w_granted_nxt = 1'b0;
          w_clear       = 1'b1;
        end
      end
      FA_SCAN: begin
        if (r_rd_addr == LAST_ADDR) begin
          w_state_nxt = FA_DRAIN;
        end else begin
          w_addr_nxt = r_rd_addr + ADDR_W'(1);
        end
      end
      FA_DRAIN: begin
        w_state_nxt   = FA_DECIDE;
        w_granted_nxt = w_pass;
      end
      FA_DECIDE: begin
        w_state_nxt = r_granted ? FA_GRANTED : FA_IDLE;
      end
      FA_GRANTED: begin
        if (bus.start) begin
          w_state_nxt   = FA_SCAN;
          w_addr_nxt    = '0;
          w_granted_nxt = 1'b0;
          w_clear       = 1'b1;
        end else if (bus.revoke || w_timeout) begin
          w_state_nxt   = FA_IDLE;
          w_granted_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = FA_IDLE;
        w_granted_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= FA_IDLE;
      r_rd_addr <= '0;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_granted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_addr <= w_addr_nxt;
      r_rd_en   <= (w_state_nxt == FA_SCAN);
      r_busy    <= (w_state_nxt == FA_SCAN) || (w_state_nxt == FA_DRAIN) ||
                   (w_state_nxt == FA_DECIDE);
      r_done    <= (w_state_nxt == FA_DECIDE);
      r_granted <= w_granted_nxt;
    end
  end

  assign bus.rd_en       = r_rd_en;
  assign bus.rd_addr     = r_rd_addr;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.granted     = r_granted;
  assign bus.match_count = w_count;

endmodule
